latch_ff_pipe: RTL and testbench

Parametrised, multi-bit successor to the single-bit latch/flip-flop primitive. It provides a configurable-depth enable-gated delay pipeline feeding a mode-selectable output register: load, toggle, sticky-set or hold. Registered per-bit rise/fall pulses and fill/valid status are also produced. It sits between a synchronous data source and downstream logic that needs delayed, accumulated or edge-annotated data on one clock.

---
 rtl/latch_ff_pipe.sv | 64 ++++++
 tb/tb_latch_ff_pipe.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/latch_ff_pipe.sv
// latch_ff_pipe: enable-gated delay pipeline feeding a load/toggle/set/hold output register with edge pulses
module latch_ff_pipe #(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         clr,
    input  logic [1:0]                   mode,
    input  logic [WIDTH-1:0]             in,
    output logic [WIDTH-1:0]             q,
    output logic                         q_vld,
    output logic [WIDTH-1:0]             rise,
    output logic [WIDTH-1:0]             fall,
    output logic [$clog2(DEPTH+1)-1:0]   fill
);
    localparam int FW = $clog2(DEPTH+1);
    logic [WIDTH-1:0] s [DEPTH];
    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] tap;
    logic [WIDTH-1:0] q_next;
    logic             upd;
    always_comb begin
        tap    = s[DEPTH-1];
        upd    = en && v[DEPTH-1];
        q_next = !upd         ? q       :
                 mode == 2'b00 ? tap     :
                 mode == 2'b01 ? q ^ tap :
                 mode == 2'b10 ? q | tap : q;
    end
    always_comb begin
        fill = '0;
        for (int i = 0; i < DEPTH; i++)
            fill = fill + FW'(v[i]);
    end
    // rise/fall are recomputed every edge, so they fall to zero whenever q holds
    always_ff @(posedge clk or negedge rst) begin
        if (!rst || clr) begin
            for (int i = 0; i < DEPTH; i++)
                s[i] <= '0;
            v     <= '0;
            q     <= RST_VAL;
            q_vld <= 1'b0;
            rise  <= '0;
            fall  <= '0;
        end else begin
            rise <= ~q & q_next;
            fall <= q & ~q_next;
            q    <= q_next;
            if (upd)
                q_vld <= 1'b1;
            if (en) begin
                s[0] <= in;
                v[0] <= 1'b1;
                for (int k = 1; k < DEPTH; k++) begin
                    s[k] <= s[k-1];
                    v[k] <= v[k-1];
                end
            end
        end
    end
endmodule

// File: tb/tb_latch_ff_pipe.sv
// tb_latch_ff_pipe: self-checking bench for latch_ff_pipe (WIDTH=8, DEPTH=4)
module tb_latch_ff_pipe;
    localparam int W = 8;
    localparam int D = 4;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         clr = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic [W-1:0] in = '0;
    logic [W-1:0] q, rise, fall;
    logic         q_vld;
    logic [2:0]   fill;
    int           total = 0;
    int           bad = 0;
    logic [W-1:0] sb [$];
    always #5 clk = ~clk;
    latch_ff_pipe #(.WIDTH(W), .DEPTH(D), .RST_VAL(8'h00)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .in(in),
        .q(q), .q_vld(q_vld), .rise(rise), .fall(fall), .fill(fill)
    );
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic do_clr();
        clr = 1'b1;
        en = 1'b1;
        cyc();
        clr = 1'b0;
    endtask
    task automatic test_reset();
        rst = 1'b0; en = 1'b1; in = 8'hFF; mode = 2'b00;
        repeat (3) cyc();
        total++; if (q !== 8'h00) begin bad++; $display("FAIL rst_q got=%h exp=%h", q, 8'h00); end
        total++; if (q_vld !== 1'b0) begin bad++; $display("FAIL rst_vld got=%b exp=0", q_vld); end
        total++; if (fill !== 3'd0) begin bad++; $display("FAIL rst_fill got=%0d exp=0", fill); end
        total++; if (rise !== 8'h00 || fall !== 8'h00) begin bad++; $display("FAIL rst_edges got=%h/%h exp=00/00", rise, fall); end
        rst = 1'b1;
        for (int k = 1; k <= D; k++) begin
            cyc();
            total++; if (fill !== 3'(k)) begin bad++; $display("FAIL rst_fill%0d got=%0d exp=%0d", k, fill, k); end
            total++; if (q_vld !== 1'b0 || q !== 8'h00 || rise !== 8'h00) begin bad++; $display("FAIL rst_hold%0d got q=%h vld=%b rise=%h exp 00/0/00", k, q, q_vld, rise); end
        end
        cyc();
        total++; if (q_vld !== 1'b1 || q !== 8'hFF) begin bad++; $display("FAIL rst_first got q=%h vld=%b exp FF/1", q, q_vld); end
    endtask
    task automatic test_load();
        logic [W-1:0] seq [5];
        seq = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
        do_clr();
        mode = 2'b00;
        for (int k = 0; k < 5; k++) begin
            in = seq[k];
            cyc();
            if (k < D) begin
                total++; if (fill !== 3'(k + 1)) begin bad++; $display("FAIL load_fill%0d got=%0d exp=%0d", k + 1, fill, k + 1); end
            end
        end
        total++; if (q !== 8'hA5) begin bad++; $display("FAIL load_q got=%h exp=A5", q); end
        total++; if (q_vld !== 1'b1) begin bad++; $display("FAIL load_vld got=%b exp=1", q_vld); end
        total++; if (rise !== 8'hA5 || fall !== 8'h00) begin bad++; $display("FAIL load_edges got=%h/%h exp=A5/00", rise, fall); end
    endtask
    task automatic test_toggle();
        logic [W-1:0] seq [7];
        seq = '{8'h0F, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        do_clr();
        for (int k = 0; k < 7; k++) begin
            mode = (k >= 5) ? 2'b01 : 2'b00;
            in = seq[k];
            cyc();
            if (k == 4) begin
                total++; if (q !== 8'h0F) begin bad++; $display("FAIL tog_pre got=%h exp=0F", q); end
            end
            if (k == 5) begin
                total++; if (q !== 8'h33) begin bad++; $display("FAIL tog_q got=%h exp=33", q); end
                total++; if (rise !== 8'h30 || fall !== 8'h0C) begin bad++; $display("FAIL tog_edges got=%h/%h exp=30/0C", rise, fall); end
            end
        end
        total++; if (q !== 8'h33 || rise !== 8'h00 || fall !== 8'h00) begin bad++; $display("FAIL tog_zero got q=%h %h/%h exp 33 00/00", q, rise, fall); end
    endtask
    task automatic test_set_hold();
        logic [W-1:0] seq [8];
        logic [1:0]   md [8];
        seq = '{8'h01, 8'h80, 8'h04, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        md = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b11};
        do_clr();
        for (int k = 0; k < 8; k++) begin
            mode = md[k];
            in = seq[k];
            cyc();
            if (k == 5) begin
                total++; if (q !== 8'h81 || rise !== 8'h80) begin bad++; $display("FAIL set1 got q=%h rise=%h exp 81/80", q, rise); end
            end
            if (k == 6) begin
                total++; if (q !== 8'h85) begin bad++; $display("FAIL set2 got=%h exp=85", q); end
            end
        end
        total++; if (q !== 8'h85 || rise !== 8'h00 || fall !== 8'h00 || q_vld !== 1'b1) begin bad++; $display("FAIL hold got q=%h %h/%h vld=%b exp 85 00/00 1", q, rise, fall, q_vld); end
    endtask
    task automatic test_stall();
        logic [W-1:0] w, prev, hq, exp;
        int n;
        n = 0;
        prev = 8'h00;
        do_clr();
        mode = 2'b00;
        sb.delete();
        for (int i = 0; i < 20; i++) begin
            if (i == 9) begin
                hq = q;
                en = 1'b0;
                for (int j = 0; j < 7; j++) begin
                    in = 8'($urandom);
                    cyc();
                    total++; if (q !== hq || fill !== 3'd4) begin bad++; $display("FAIL stall%0d got q=%h fill=%0d exp %h/4", j, q, fill, hq); end
                    total++; if (rise !== 8'h00 || fall !== 8'h00) begin bad++; $display("FAIL stall_edges%0d got=%h/%h exp=00/00", j, rise, fall); end
                end
            end
            w = 8'($urandom);
            in = w;
            en = 1'b1;
            sb.push_back(w);
            cyc();
            n++;
            if (n >= D + 1) begin
                exp = sb.pop_front();
                total++; if (q !== exp || q_vld !== 1'b1) begin bad++; $display("FAIL stream%0d got q=%h vld=%b exp %h/1", n, q, q_vld, exp); end
                total++; if (rise !== (~prev & exp) || fall !== (prev & ~exp)) begin bad++; $display("FAIL stream_edges%0d got=%h/%h exp=%h/%h", n, rise, fall, ~prev & exp, prev & ~exp); end
                prev = exp;
            end
        end
    endtask
    task automatic test_clr_rst();
        do_clr();
        mode = 2'b00;
        repeat (3) begin in = 8'h77; cyc(); end
        total++; if (fill !== 3'd3) begin bad++; $display("FAIL clr_pre got=%0d exp=3", fill); end
        clr = 1'b1; en = 1'b1; mode = 2'b01; in = 8'h11;
        cyc();
        clr = 1'b0; mode = 2'b00;
        total++; if (fill !== 3'd0 || q !== 8'h00 || q_vld !== 1'b0) begin bad++; $display("FAIL clr got fill=%0d q=%h vld=%b exp 0/00/0", fill, q, q_vld); end
        for (int k = 0; k < 5; k++) begin
            in = (k == 0) ? 8'h5A : 8'h00;
            cyc();
            if (k == 3) begin
                total++; if (q_vld !== 1'b0) begin bad++; $display("FAIL clr_early got vld=%b exp=0", q_vld); end
            end
        end
        total++; if (q !== 8'h5A || q_vld !== 1'b1 || rise !== 8'h5A) begin bad++; $display("FAIL clr_refill got q=%h vld=%b rise=%h exp 5A/1/5A", q, q_vld, rise); end
        #1 rst = 1'b0;
        #1;
        total++; if (q !== 8'h00 || q_vld !== 1'b0 || fill !== 3'd0 || rise !== 8'h00) begin bad++; $display("FAIL async_rst got q=%h vld=%b fill=%0d rise=%h exp 00/0/0/00", q, q_vld, fill, rise); end
        cyc();
        rst = 1'b1;
    endtask
    initial begin
        test_reset();
        test_load();
        test_toggle();
        test_set_hold();
        test_stall();
        test_clr_rst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
